// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder front end.
package nsa_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } nsa_state_t;

    // Step counter width: enough to hold NIB-1, plus one spare bit.
    function automatic int unsigned idx_width(input int unsigned width);
        return $clog2(width / NIBBLE_W) + 1;
    endfunction

endpackage

// File: rtl/nsa_nibble_shifter.sv
// WIDTH-bit register that loads in parallel or shifts right by one nibble,
// inserting a new nibble at the top.
module nsa_nibble_shifter
    import nsa_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_load,
    input  logic [WIDTH-1:0]    i_load_val,
    input  logic                i_shift,
    input  logic [NIBBLE_W-1:0] i_nib_in,
    output logic [NIBBLE_W-1:0] o_nib,
    output logic [WIDTH-1:0]    o_next
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_shifted;

    // A single-nibble register degenerates to a plain replacement.
    generate
        if (WIDTH == NIBBLE_W) begin : g_one_nib
            assign w_shifted = i_nib_in;
        end else begin : g_multi_nib
            assign w_shifted = {i_nib_in, r_q[WIDTH-1:NIBBLE_W]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_load_val;
        end else if (i_shift) begin
            r_q <= w_shifted;
        end
    end

    assign o_nib  = r_q[NIBBLE_W-1:0];
    assign o_next = w_shifted;

endmodule

// File: rtl/nibble_serial_adder.sv
// Sequential WIDTH-bit adder feeding an external 4-bit Adder one nibble per cycle.
// Optional subtract mode and signed overflow flag under macro NSA_SUB_EN.
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
`ifdef NSA_SUB_EN
    input  logic                sub,
    output logic                ovf,
`endif
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [WIDTH-1:0]    op_a,
    input  logic [WIDTH-1:0]    op_b,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [WIDTH-1:0]    sum,
    output logic                cout,
    output logic [NIBBLE_W-1:0] add_a,
    output logic [NIBBLE_W-1:0] add_b,
    output logic                add_cin,
    input  logic [NIBBLE_W-1:0] add_sum,
    input  logic                add_cout
);

    localparam int unsigned NIB   = WIDTH / NIBBLE_W;
    localparam int unsigned IDX_W = idx_width(WIDTH);

    nsa_state_t r_state;
    nsa_state_t w_state_nxt;

    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic                w_load;
    logic                w_shift;
    logic                w_last;
    logic [WIDTH-1:0]    w_b_load;
    logic                w_cin_load;
    logic [NIBBLE_W-1:0] w_a_nib;
    logic [NIBBLE_W-1:0] w_b_nib;
    logic [NIBBLE_W-1:0] w_r_nib_unused;
    logic [WIDTH-1:0]    w_a_next_unused;
    logic [WIDTH-1:0]    w_b_next_unused;
    logic [WIDTH-1:0]    w_r_next;

`ifdef NSA_SUB_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;

    // Subtract as a + ~b + 1; the carry-in port is ignored in that mode.
    assign w_b_load   = sub ? ~op_b : op_b;
    assign w_cin_load = sub | cin;
    assign ovf        = r_ovf;
`else
    assign w_b_load   = op_b;
    assign w_cin_load = cin;
`endif

    nsa_nibble_shifter #(.WIDTH(WIDTH)) u_a_sh (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (op_a),
        .i_shift    (w_shift),
        .i_nib_in   ('0),
        .o_nib      (w_a_nib),
        .o_next     (w_a_next_unused)
    );

    nsa_nibble_shifter #(.WIDTH(WIDTH)) u_b_sh (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_b_load),
        .i_shift    (w_shift),
        .i_nib_in   ('0),
        .o_nib      (w_b_nib),
        .o_next     (w_b_next_unused)
    );

    // Result collector: Adder sums enter at the top, so LSB nibble ends lowest.
    nsa_nibble_shifter #(.WIDTH(WIDTH)) u_r_sh (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val ('0),
        .i_shift    (w_shift),
        .i_nib_in   (add_sum),
        .o_nib      (w_r_nib_unused),
        .o_next     (w_r_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and the combinational drive toward the Adder.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_last      = 1'b0;
        add_a       = '0;
        add_b       = '0;
        add_cin     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_shift = 1'b1;
                add_a   = w_a_nib;
                add_b   = w_b_nib;
                add_cin = r_carry;
                if (r_idx == IDX_W'(NIB - 1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
`ifdef NSA_SUB_EN
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
`endif
        end else begin
            if (w_load) begin
                r_carry <= w_cin_load;
                r_idx   <= '0;
`ifdef NSA_SUB_EN
                r_a_msb <= op_a[WIDTH-1];
                r_b_msb <= w_b_load[WIDTH-1];
`endif
            end else if (w_shift) begin
                r_carry <= add_cout;
                r_idx   <= r_idx + IDX_W'(1);
            end
            if (w_last) begin
                r_sum  <= w_r_next;
                r_cout <= add_cout;
`ifdef NSA_SUB_EN
                r_ovf  <= (r_a_msb == r_b_msb) && (w_r_next[WIDTH-1] != r_a_msb);
`endif
            end
        end
    end

    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder (WIDTH=16) with a behavioural 4-bit Adder beside it.
// Subtract cases run when NSA_SUB_EN is defined.
module tb_nibble_serial_adder;

    localparam int NIB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] op_a, op_b;
    logic        cin;
    logic        busy, done, cout;
    logic [15:0] sum;
    logic [3:0]  add_a, add_b, add_sum;
    logic        add_cin, add_cout;
    logic        tb_sub = 1'b0;
`ifdef NSA_SUB_EN
    logic        ovf;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // The external 4-bit Adder stage.
    assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

    nibble_serial_adder #(.WIDTH(16)) dut (
`ifdef NSA_SUB_EN
        .sub      (tb_sub),
        .ovf      (ovf),
`endif
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: phase counts cycles since acceptance (0 = idle, 1..NIB = nibble steps, NIB+1 = done).
    int          m_phase;
    logic [15:0] m_a, m_beff;
    logic        m_c;
    logic [15:0] m_sum;
    logic        m_cout, m_ovf;
    logic [16:0] m_full;

    assign m_full = 17'(m_a) + 17'(m_beff) + 17'(m_c);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_a     <= '0;
            m_beff  <= '0;
            m_c     <= 1'b0;
            m_sum   <= '0;
            m_cout  <= 1'b0;
            m_ovf   <= 1'b0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_phase <= 1;
                m_a     <= op_a;
                m_beff  <= tb_sub ? ~op_b : op_b;
                m_c     <= tb_sub | cin;
            end
        end else begin
            m_phase <= (m_phase == NIB + 1) ? 0 : m_phase + 1;
            if (m_phase == NIB) begin
                m_sum  <= m_full[15:0];
                m_cout <= m_full[16];
                m_ovf  <= (m_a[15] == m_beff[15]) && (m_full[15] != m_a[15]);
            end
        end
    end

    // Carry entering bit position pos of the full-width addition.
    function automatic logic carry_into(input int pos);
        logic [15:0] mask;
        logic [16:0] s;
        mask = (pos == 0) ? 16'h0 : 16'((17'd1 << pos) - 17'd1);
        s    = 17'(m_a & mask) + 17'(m_beff & mask) + 17'(m_c);
        return s[pos];
    endfunction

    always @(negedge clk) begin
        logic [3:0] ea, eb;
        logic       ec;
        if (rst_n) begin
            ea = 4'h0; eb = 4'h0; ec = 1'b0;
            if (m_phase >= 1 && m_phase <= NIB) begin
                ea = m_a[4*(m_phase-1) +: 4];
                eb = m_beff[4*(m_phase-1) +: 4];
                ec = carry_into(4*(m_phase-1));
            end
            chk("busy", busy, m_phase != 0);
            chk("done", done, m_phase == NIB + 1);
            chk("add_a", add_a, ea);
            chk("add_b", add_b, eb);
            chk("add_cin", add_cin, ec);
            chk("sum", sum, m_sum);
            chk("cout", cout, m_cout);
`ifdef NSA_SUB_EN
            chk("ovf", ovf, m_ovf);
`endif
        end
    end

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                          input logic s, input bit poke, input logic [15:0] exp_sum,
                          input logic exp_cout, input logic exp_ovf);
        int n, nbusy;
        bit seen;
        @(posedge clk); #1;
        op_a = a; op_b = b; cin = c; tb_sub = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op_a = 16'($urandom); op_b = 16'($urandom); cin = 1'($urandom);
        n = 0; nbusy = 0; seen = 0;
        while (n < 20 && !seen) begin
            @(negedge clk);
            n++;
            if (busy) nbusy++;
            if (done) begin
                seen = 1;
            end else begin
                @(posedge clk); #1;
                start = (poke && n == 2);
                if (start) begin
                    op_a = 16'hAAAA; op_b = 16'h5555;
                end
            end
        end
        start = 1'b0;
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency", n, 5);
        chk("busy_cycles", nbusy, 5);
        chk("lit_sum", sum, 32'(exp_sum));
        chk("lit_cout", cout, 32'(exp_cout));
`ifdef NSA_SUB_EN
        chk("lit_ovf", ovf, 32'(exp_ovf));
`else
        if (exp_ovf) n_checks = n_checks + 0;
`endif
    endtask

    initial begin
        bit saw;
        rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_add", {add_a, add_b, add_cin}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, 16'h5555, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 16'h0000, 1'b1, 1'b0);
        run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, 16'h0000, 1'b1, 1'b0);
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1, 16'h0002, 1'b0, 1'b0);

        // Abort mid-RUN with asynchronous reset.
        @(posedge clk); #1;
        op_a = 16'h1111; op_b = 16'h2222; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cout", cout, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        saw = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) saw = 1;
        end
        chk("abort_no_done", 32'(saw), 0);

        run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 0, 16'h1000, 1'b0, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 0, 16'h0000, 1'b1, 1'b1);
`ifdef NSA_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 16'hFFFE, 1'b0, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 0, 16'h7FFF, 1'b1, 1'b1);
        tb_sub = 1'b0;
`endif
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
